// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Divide-by-zero and signed overflow finish one cycle after start.
module ex_div (
  input  logic        ck_i,
  input  logic        rs_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  rd_wa_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_wa_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        is_rem, neg_q, neg_r;
  logic        accept, div_zero, ovf, is_signed;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted, trial;
  logic [31:0] quo_nxt, rem_nxt, q_fix, r_fix;

  assign is_signed = ~op_i[0];
  assign accept    = (state == IDLE) && start_i && !flush_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = is_signed && (dividend_i == 32'h8000_0000) && (divisor_i == '1);
  assign a_abs     = (is_signed && dividend_i[31]) ? -dividend_i : dividend_i;
  assign b_abs     = (is_signed && divisor_i[31])  ? -divisor_i  : divisor_i;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[32]) begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
    q_fix = neg_q ? -quo_nxt : quo_nxt;
    r_fix = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge ck_i) begin
    if (rs_i) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge ck_i) begin
    if (rs_i) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      rd_wa_o  <= '0;
    end else if (accept) begin
      rd_wa_o <= rd_wa_i;
      is_rem  <= op_i[1];
      neg_q   <= is_signed && (dividend_i[31] ^ divisor_i[31]);
      neg_r   <= is_signed && dividend_i[31];
      quo     <= a_abs;
      dvs     <= b_abs;
      rem     <= '0;
      cnt     <= '0;
      if (div_zero)  result_o <= op_i[1] ? dividend_i : '1;
      else if (ovf)  result_o <= op_i[1] ? '0 : 32'h8000_0000;
    end else if (state == CALC && !flush_i) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + 6'd1;
      if (cnt == 6'd31) result_o <= is_rem ? r_fix : q_fix;
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign rd_we_o     = done_o;
  assign stall_req_o = accept || (state == CALC);

endmodule
